// File: rtl/byte_dispatch_seq.sv
// byte_dispatch_seq: captures an NUM_BYTES-wide payload plus lane mask and
// dispatches each selected byte to a downstream 3-bit demux, one write strobe
// per set mask bit in ascending lane order, with optional idle gaps between
// strobes and a downstream stall input.
// Optional feature macro: BYTE_DISPATCH_IRQ_EN adds a sticky irq output that
// sets after each completed payload and is cleared by irq_clr.
module byte_dispatch_seq #(
  parameter int NUM_BYTES  = 5,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [NUM_BYTES-1:0]   in_mask,
  input  logic                   out_hold,
  output logic [2:0]             sel,
  output logic [7:0]             data_out,
  output logic                   we,
  output logic                   busy,
`ifdef BYTE_DISPATCH_IRQ_EN
  output logic                   done,
  output logic                   irq,
  input  logic                   irq_clr
`else
  output logic                   done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [3:0]               gap_q, gap_d;
  logic [8*NUM_BYTES-1:0]   data_q, data_d;
  logic [NUM_BYTES-1:0]     mask_q, mask_d;
`ifdef BYTE_DISPATCH_IRQ_EN
  logic                     irq_q, irq_d;
`endif

  // Lanes still to be sent after the current one: set mask bits above idx.
  logic [NUM_BYTES-1:0]     above_idx;
  logic [2:0]               first_idx;
  logic [2:0]               next_idx;
  logic                     next_found;
  logic [7:0]               cur_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_above
      assign above_idx[gi] = mask_q[gi] && (3'(gi) > idx_q);
    end
  endgenerate

  // Priority searches: lowest set bit of the incoming mask, lowest pending
  // lane above idx, and the captured byte currently addressed by idx.
  always_comb begin
    first_idx  = 3'd0;
    next_idx   = 3'd0;
    next_found = 1'b0;
    cur_byte   = 8'h00;
    for (int k = NUM_BYTES - 1; k >= 0; k--) begin
      if (in_mask[k]) begin
        first_idx = 3'(k);
      end
      if (above_idx[k]) begin
        next_idx   = 3'(k);
        next_found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx_q == 3'(k)) begin
        cur_byte = data_q[8*k +: 8];
      end
    end
  end

  // State register: all flops, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      gap_q   <= 4'd0;
      data_q  <= '0;
      mask_q  <= '0;
`ifdef BYTE_DISPATCH_IRQ_EN
      irq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
`ifdef BYTE_DISPATCH_IRQ_EN
      irq_q   <= irq_d;
`endif
    end
  end

  // Next-state logic: capture, lane stepping, gap countdown and completion.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mask_d = in_mask;
          if (in_mask == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
            idx_d   = first_idx;
          end
        end
      end
      S_SEND: begin
        // A stall keeps state and idx so the same byte is reissued later.
        if (!out_hold) begin
          if (next_found) begin
            idx_d = next_idx;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = 4'(GAP_CYCLES - 1);
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        // Counts down regardless of out_hold; the stall only affects SEND.
        if (gap_q == 4'd0) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef BYTE_DISPATCH_IRQ_EN
  // Sticky interrupt: set wins over a clear arriving in the same cycle.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (state_q == S_DONE) begin
      irq_d = 1'b1;
    end
  end

  assign irq = irq_q;
`endif

  // Outputs: demux is parked on lane 7 with zero data whenever no strobe.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    we       = (state_q == S_SEND) && !out_hold;
    sel      = we ? idx_q : 3'b111;
    data_out = we ? cur_byte : 8'h00;
  end

endmodule

// File: tb/tb_byte_dispatch_seq.sv
// Bench for byte_dispatch_seq: two instances (GAP_CYCLES 0 and 2) share one
// stimulus stream; a lane-queue model predicts every output each cycle, and
// directed payloads are pinned with literal strobe/done timing.
module tb_byte_dispatch_seq;

  localparam int NB   = 5;
  localparam int GAP0 = 0;
  localparam int GAP1 = 2;
  localparam int LOGN = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [39:0]   in_data;
  logic [4:0]    in_mask;
  logic          out_hold;
  logic          irq_clr;

  logic          rdy_w  [2];
  logic          we_w   [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic [2:0]    sel_w  [2];
  logic [7:0]    dat_w  [2];
`ifdef BYTE_DISPATCH_IRQ_EN
  logic          irq_w  [2];
`endif

  always #5 clk = ~clk;

  byte_dispatch_seq #(.NUM_BYTES(NB), .GAP_CYCLES(GAP0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_data(in_data), .in_mask(in_mask), .out_hold(out_hold),
    .sel(sel_w[0]), .data_out(dat_w[0]), .we(we_w[0]), .busy(busy_w[0]),
`ifdef BYTE_DISPATCH_IRQ_EN
    .done(done_w[0]), .irq(irq_w[0]), .irq_clr(irq_clr)
`else
    .done(done_w[0])
`endif
  );

  byte_dispatch_seq #(.NUM_BYTES(NB), .GAP_CYCLES(GAP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_data(in_data), .in_mask(in_mask), .out_hold(out_hold),
    .sel(sel_w[1]), .data_out(dat_w[1]), .we(we_w[1]), .busy(busy_w[1]),
`ifdef BYTE_DISPATCH_IRQ_EN
    .done(done_w[1]), .irq(irq_w[1]), .irq_clr(irq_clr)
`else
    .done(done_w[1])
`endif
  );

  // Model: a payload is a set of pending lanes; each cycle is either idle,
  // a gap cycle, a strobe of the lowest pending lane, or the done cycle.
  logic          busy_m [2];
  logic          done_m [2];
  int            gap_m  [2];
  logic [7:0]    pend_m [2];
  logic [39:0]   data_m [2];
  logic          irq_m  [2];
  int            hs     [2];
  int            cyc = 0;

  int checks = 0;
  int fails  = 0;

  // Strobe / done logs for the directed payloads.
  int st_cyc [2][LOGN];
  int st_sel [2][LOGN];
  int st_dat [2][LOGN];
  int st_n   [2];
  int dn_cyc [2][LOGN];
  int dn_n   [2];
  int sb     [2];
  int db     [2];
  bit log_en;

  function automatic int lowest(input logic [7:0] m);
    int r = -1;
    for (int k = 7; k >= 0; k--) if (m[k]) r = k;
    return r;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  // Model update at each rising edge from the inputs present during the cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        busy_m[i] <= 1'b0;
        done_m[i] <= 1'b0;
        gap_m[i]  <= 0;
        pend_m[i] <= 8'h00;
        data_m[i] <= 40'h0;
        irq_m[i]  <= 1'b0;
      end else begin
        if (busy_m[i] && done_m[i]) irq_m[i] <= 1'b1;
        else if (irq_clr)           irq_m[i] <= 1'b0;
        if (!busy_m[i]) begin
          if (in_valid) begin
            data_m[i] <= in_data;
            pend_m[i] <= {3'b000, in_mask};
            busy_m[i] <= 1'b1;
            done_m[i] <= (in_mask == 5'd0);
            gap_m[i]  <= 0;
            hs[i]     <= cyc + 1;
          end
        end else if (done_m[i]) begin
          busy_m[i] <= 1'b0;
          done_m[i] <= 1'b0;
        end else if (gap_m[i] > 0) begin
          gap_m[i] <= gap_m[i] - 1;
        end else if (!out_hold) begin
          pend_m[i] <= pend_m[i] & ~(8'd1 << lowest(pend_m[i]));
          if ((pend_m[i] & ~(8'd1 << lowest(pend_m[i]))) == 8'h00) done_m[i] <= 1'b1;
          else gap_m[i] <= gap_of(i);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // One cycle: compare every output against the model mid-cycle, log, advance.
  task automatic tick();
    logic snd;
    int   ln;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      snd = busy_m[i] && !done_m[i] && (gap_m[i] == 0) && !out_hold;
      ln  = lowest(pend_m[i]);
      chk($sformatf("in_ready%0d", i), rdy_w[i],  !busy_m[i]);
      chk($sformatf("busy%0d", i),     busy_w[i], busy_m[i]);
      chk($sformatf("done%0d", i),     done_w[i], busy_m[i] && done_m[i]);
      chk($sformatf("we%0d", i),       we_w[i],   snd);
      chk($sformatf("sel%0d", i),      sel_w[i],  snd ? 3'(ln) : 3'b111);
      chk($sformatf("data_out%0d", i), dat_w[i],  snd ? data_m[i][8*ln +: 8] : 8'h00);
`ifdef BYTE_DISPATCH_IRQ_EN
      chk($sformatf("irq%0d", i),      irq_w[i],  irq_m[i]);
`endif
      if (log_en && we_w[i] && st_n[i] < LOGN) begin
        st_cyc[i][st_n[i]] = cyc;
        st_sel[i][st_n[i]] = int'(sel_w[i]);
        st_dat[i][st_n[i]] = int'(dat_w[i]);
        st_n[i]++;
      end
      if (log_en && done_w[i] && dn_n[i] < LOGN) begin
        dn_cyc[i][dn_n[i]] = cyc;
        dn_n[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string nm, input logic [39:0] d, input logic [4:0] m);
    for (int i = 0; i < 2; i++) begin
      sb[i] = st_n[i];
      db[i] = dn_n[i];
    end
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    tick();
    in_valid = 1'b0;
    $display("payload %s data=%010h mask=%05b handshake_cyc=%0d", nm, d, m, hs[0]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_w[0] || busy_w[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < budget, 1'b1);
  endtask

  // Literal check of the k-th strobe of instance i in the current payload.
  task automatic chk_strobe(input string nm, input int i, input int k,
                            input int s, input int d, input int c);
    int j = sb[i] + k;
    if (j >= LOGN) j = LOGN - 1;
    chk({nm, "_sel"}, st_sel[i][j], s);
    chk({nm, "_dat"}, st_dat[i][j], d);
    chk({nm, "_cyc"}, st_cyc[i][j], c);
  endtask

  task automatic chk_done(input string nm, input int i, input int c);
    int j = db[i];
    if (j >= LOGN) j = LOGN - 1;
    chk({nm, "_done_cnt"}, dn_n[i] - db[i], 1);
    chk({nm, "_done_cyc"}, dn_cyc[i][j], c);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 40'h0;
    in_mask  = 5'h0;
    out_hold = 1'b0;
    irq_clr  = 1'b0;
    log_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st_n[i] = 0;
      dn_n[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", rdy_w[i], 1'b1);
      chk("rst_we",       we_w[i],  1'b0);
      chk("rst_sel",      sel_w[i], 3'b111);
      chk("rst_data",     dat_w[i], 8'h00);
      chk("rst_busy",     busy_w[i], 1'b0);
      chk("rst_done",     done_w[i], 1'b0);
    end
    rst_n = 1'b1;
    tick();

    // Full mask, no gap: five back-to-back strobes then done.
    send("A", 40'h44_33_22_11_00, 5'b11111);
    wait_idle(60);
    chk("A_cnt0", st_n[0] - sb[0], 5);
    chk("A_cnt1", st_n[1] - sb[1], 5);
    for (int k = 0; k < 5; k++) begin
      chk_strobe("A0", 0, k, k, 17 * k, hs[0] + k);
      chk_strobe("A1", 1, k, k, 17 * k, hs[1] + 3 * k);
    end
    chk_done("A0", 0, hs[0] + 5);
    chk_done("A1", 1, hs[1] + 13);

    // Sparse mask: lanes 2 and 4 only.
    send("B", 40'h44_33_22_11_00, 5'b10100);
    wait_idle(60);
    chk("B_cnt0", st_n[0] - sb[0], 2);
    chk_strobe("B0", 0, 0, 2, 8'h22, hs[0]);
    chk_strobe("B0", 0, 1, 4, 8'h44, hs[0] + 1);
    chk_strobe("B1", 1, 1, 4, 8'h44, hs[1] + 3);
    chk_done("B0", 0, hs[0] + 2);

    // Empty mask: straight to done, ready the following cycle.
    send("C", 40'hAA_BB_CC_DD_EE, 5'b00000);
    chk("C_ready_in_done", rdy_w[0], 1'b0);
    chk("C_done_now", done_w[0], 1'b1);
    tick();
    chk("C_ready_after", rdy_w[0], 1'b1);
    chk("C_cnt0", st_n[0] - sb[0], 0);
    chk_done("C0", 0, hs[0]);

    // Stall for three cycles while lane 1 is pending.
    send("D", 40'h44_33_22_11_00, 5'b11111);
    tick();
    out_hold = 1'b1;
    repeat (3) tick();
    out_hold = 1'b0;
    wait_idle(60);
    chk("D_cnt0", st_n[0] - sb[0], 5);
    chk("D_cnt1", st_n[1] - sb[1], 5);
    chk_strobe("D0", 0, 1, 1, 8'h11, hs[0] + 4);
    chk_strobe("D0", 0, 4, 4, 8'h44, hs[0] + 7);
    chk_strobe("D1", 1, 1, 1, 8'h11, hs[1] + 4);
    chk_done("D0", 0, hs[0] + 8);

    // Gap spacing, with an in_valid pulse mid-payload that must be ignored.
    send("E", 40'h44_33_22_11_00, 5'b11111);
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 40'h99_88_77_66_55;
    in_mask  = 5'b00001;
    tick();
    in_valid = 1'b0;
    wait_idle(60);
    repeat (3) tick();
    chk("E_cnt0", st_n[0] - sb[0], 5);
    chk("E_cnt1", st_n[1] - sb[1], 5);
    for (int k = 0; k < 5; k++) chk_strobe("E1", 1, k, k, 17 * k, hs[1] + 3 * k);
    chk_done("E1", 1, hs[1] + 13);

    // Reset after the second strobe aborts the payload.
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    send("F", 40'h44_33_22_11_00, 5'b11111);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("F_we",   we_w[0],   1'b0);
    chk("F_sel",  sel_w[0],  3'b111);
    chk("F_busy", busy_w[0], 1'b0);
    chk("F_busy1", busy_w[1], 1'b0);
`ifdef BYTE_DISPATCH_IRQ_EN
    chk("F_irq", irq_w[0], 1'b0);
`endif
    repeat (4) tick();
    chk("F_cnt0", st_n[0] - sb[0], 2);
    chk("F_done0", dn_n[0] - db[0], 0);
    chk("F_done1", dn_n[1] - db[1], 0);

    // Randomized traffic against the model.
    log_en = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = {8'($urandom), $urandom};
      in_mask  = 5'($urandom);
      out_hold = ($urandom_range(0, 3) == 0);
      irq_clr  = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_hold = 1'b0;
    irq_clr  = 1'b0;
    wait_idle(100);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/byte_dispatch_seq.md
BYTE_DISPATCH_SEQ -- requirements
Module: byte_dispatch_seq

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 5, number of byte lanes dispatched; legal range 1..7.
REQ-002 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between consecutive write strobes; legal range 0..15.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  payload offered.
REQ-007 in_ready  output  1  sequencer can accept a payload.
REQ-008 in_data  input  8*NUM_BYTES  payload; byte k = in_data[8k+7:8k].
REQ-009 in_mask  input  NUM_BYTES  bit k=1 means byte k is dispatched.
REQ-010 out_hold  input  1  downstream stall; freezes dispatch.
REQ-011 sel  output  3  destination lane index driven to the downstream 3-bit demux select.
REQ-012 data_out  output  8  byte driven to the downstream demux data input.
REQ-013 we  output  1  write strobe; lane sel latches data_out when we=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a payload finishes.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 On in_valid&in_ready, the block SHALL capture in_data and in_mask; in_valid while busy SHALL be ignored.
REQ-019 After capture, mask==0 SHALL go to DONE with no strobe; otherwise SHALL go to SEND with idx = lowest set mask bit.
REQ-020 In SEND with out_hold=0: we=1, sel=idx, data_out=byte[idx]. Next state: GAP if another set bit exists above idx and GAP_CYCLES>0, else SEND at the next set bit, else DONE.
REQ-021 In SEND with out_hold=1: we=0, state/idx SHALL hold, and the same byte SHALL be issued once hold drops.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with we=0, then return to SEND; out_hold SHALL NOT extend GAP.
REQ-023 Whenever we=0, sel SHALL be 3'b111 and data_out SHALL be 8'h00, so the downstream demux routes nothing.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 Latency: handshake at edge N gives first we in cycle N+1; with full mask, GAP_CYCLES=0 and no hold, we is high in N+1..N+NUM_BYTES, done in N+NUM_BYTES+1, and in_ready in N+NUM_BYTES+2.
REQ-026 Each set mask bit SHALL produce exactly one we cycle, in ascending lane order; cleared lanes SHALL take zero cycles.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE, idx=0, gap counter=0, captured data/mask=0.
REQ-028 Reset values: in_ready=1 after the reset edge, we=0, sel=3'b111, data_out=8'h00, busy=0, done=0.
REQ-029 Reset mid-payload SHALL abort with no done pulse and no further strobes; the captured payload is discarded.

Configuration
REQ-030 Macro BYTE_DISPATCH_IRQ_EN SHALL add ports irq (output 1) and irq_clr (input 1).
REQ-031 With the macro defined: irq SHALL set on the cycle after done; irq_clr SHALL clear it; a simultaneous set and clear SHALL leave irq=1; reset SHALL clear irq.
REQ-032 Without the macro: the ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then in_data=40'h44_33_22_11_00, mask=5'b11111, GAP=0 -> we in 5 consecutive cycles with (sel,data_out)=(0,00),(1,11),(2,22),(3,33),(4,44), then a single done.
REQ-034 mask=5'b10100 -> exactly two strobes, (2,22) then (4,44); sel=7/data 00 otherwise.
REQ-035 mask=5'b00000 -> no we, done one cycle after the handshake, in_ready back the following cycle.
REQ-036 out_hold=1 for 3 cycles during lane 1 -> we=0 for those 3 cycles, then (1,11) issued once, with total payload time extended by 3.
REQ-037 GAP_CYCLES=2, full mask -> exactly 2 idle cycles between each pair of strobes; in_valid pulsed mid-payload is ignored.
REQ-038 rst_n=0 after the second strobe -> we=0, sel=7, busy=0 next cycle, no done; with BYTE_DISPATCH_IRQ_EN, irq stays 0.
